uart_tx_engine: RTL and testbench

Parametrised UART transmitter. Accepts a parallel word on a valid/ready handshake and serialises it LSB-first with a start bit, an optional parity bit and one or two stop bits. Bit timing comes from an internal baud counter. Replaces the fixed 8-bit, one-stop-bit transmit controller, and drives the board TX pin directly through a registered output.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_counter.sv | 46 ++++
 rtl/uart_tx_engine.sv | 127 ++++++++++++
 tb/tb_uart_tx_engine.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM/parity encodings, default bit timing and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int MAX_DATA_W           = 9;

  // Narrower words are zero-extended by the caller; the zeros do not change the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input parity_t mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: calc_parity = p;
      PAR_ODD:  calc_parity = ~p;
      default:  calc_parity = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts clk cycles and flags the last cycle of each serial bit.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          tick_r;

  // Next count: forced to zero on clear, wraps after the last cycle of a bit.
  always_comb begin
    count_next_s = count_r;
    if (clear) begin
      count_next_s = '0;
    end else if (count_r == LAST_CNT) begin
      count_next_s = '0;
    end else begin
      count_next_s = count_r + CNT_ONE;
    end
  end

  // Count register plus a registered tick that mirrors count_r == LAST_CNT.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      tick_r  <= (count_next_s == LAST_CNT);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: valid/ready word in, LSB-first serial frame out with optional parity
// and one or two stop bits; tx is registered and trails the FSM state by one cycle.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam parity_t PAR_MODE = (PARITY == 2) ? PAR_ODD :
                                 (PARITY == 1) ? PAR_EVEN : PAR_NONE;

  tx_state_t         state_r;
  logic [DATA_W-1:0] shift_r;
  logic [BW-1:0]     bit_idx_r;
  logic              stop_cnt_r;
  logic              par_r;
  logic              tx_r;

  logic tick_s;
  logic final_s;
  logic ready_s;
  logic xfer_s;
  logic clear_s;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // Handshake and end-of-frame decode; all terms come from registers except tx_valid.
  always_comb begin
    final_s = (state_r == STOP) && tick_s && (stop_cnt_r == STOP_LAST);
    ready_s = (state_r == IDLE) || final_s;
    xfer_s  = tx_valid && ready_s;
    clear_s = (state_r == IDLE) || xfer_s;
  end

  // Frame FSM; tx_r is loaded from the current state so the line lags state entry by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      bit_idx_r  <= '0;
      stop_cnt_r <= 1'b0;
      par_r      <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          tx_r <= 1'b1;
          if (xfer_s) begin
            state_r <= START;
          end
        end
        START: begin
          tx_r <= 1'b0;
          if (tick_s) begin
            state_r <= DATA;
          end
        end
        DATA: begin
          tx_r <= shift_r[0];
          if (tick_s) begin
            shift_r   <= shift_r >> 1;
            bit_idx_r <= bit_idx_r + BIT_ONE;
            if (bit_idx_r == LAST_BIT) begin
              state_r    <= (PAR_MODE != PAR_NONE) ? PAR : STOP;
              stop_cnt_r <= 1'b0;
            end
          end
        end
        PAR: begin
          tx_r <= par_r;
          if (tick_s) begin
            state_r    <= STOP;
            stop_cnt_r <= 1'b0;
          end
        end
        STOP: begin
          tx_r <= 1'b1;
          if (tick_s) begin
            if (stop_cnt_r == STOP_LAST) begin
              state_r <= xfer_s ? START : IDLE;
            end else begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
        end
      endcase
      if (xfer_s) begin
        shift_r   <= tx_data;
        bit_idx_r <= '0;
        par_r     <= calc_parity(MAX_DATA_W'(tx_data), PAR_MODE);
      end
    end
  end

  assign tx_ready = ready_s;
  assign tx       = tx_r;
  assign busy     = (state_r != IDLE);
  assign done     = final_s;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine across four parameter sets, with a per-cycle tx scoreboard.
module tb_uart_tx_engine;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid_v;
  logic [3:0] ready_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [8:0] data_v [4];

  int   tests = 0;
  int   fails = 0;
  logic exp_q [$];
  int   f;
  int   f2;

  always #5 clk = ~clk;

  uart_tx_engine #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(data_v[0][7:0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  uart_tx_engine #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(data_v[1][7:0]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  uart_tx_engine #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(data_v[2][7:0]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  uart_tx_engine #(.DATA_W(7), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .tx_data(data_v[3][6:0]), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for every clock of one frame.
  task automatic push_frame(input logic [8:0] word, input int dw, input int par,
                            input int stops, output int cycles);
    logic bits [$];
    logic p;
    bits.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < dw; i++) begin
      bits.push_back(word[i]);
      p = p ^ word[i];
    end
    if (par == 1) bits.push_back(p);
    if (par == 2) bits.push_back(~p);
    for (int i = 0; i < stops; i++) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c < CPB; c++) exp_q.push_back(bits[i]);
    end
    cycles = bits.size() * CPB;
  endtask

  task automatic handshake(input int d, input logic [8:0] word, input bit hold);
    chk($sformatf("ready_before_send_d%0d", d), 32'(ready_v[d]), 32'd1);
    valid_v[d] = 1'b1;
    data_v[d]  = word;
    step();
    if (!hold) valid_v[d] = 1'b0;
  endtask

  // k counts edges after the handshake edge; checks line, done, busy and ready every cycle.
  task automatic watch(input int d, input int total, input int f1, input bit two,
                       input bit scramble, input string tag);
    logic e;
    logic de;
    for (int k = 0; k <= total; k++) begin
      if (k > 0) step();
      if (two && k == f1) valid_v[d] = 1'b0;
      if (scramble) data_v[d] = 9'($urandom);
      e  = (k == 0) ? 1'b1 : exp_q.pop_front();
      de = (k == f1 - 1) || (two && k == total - 1);
      chk($sformatf("%s_tx_k%0d", tag, k), 32'(tx_v[d]), 32'(e));
      chk($sformatf("%s_done_k%0d", tag, k), 32'(done_v[d]), 32'(de));
      chk($sformatf("%s_busy_k%0d", tag, k), 32'(busy_v[d]), 32'(k < total));
      chk($sformatf("%s_ready_k%0d", tag, k), 32'(ready_v[d]), 32'(de || k >= total));
    end
    chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    valid_v = 4'b0000;
    for (int i = 0; i < 4; i++) data_v[i] = 9'h000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < 20; k++) begin
      chk("idle_tx", 32'(tx_v), 32'hF);
      chk("idle_busy", 32'(busy_v), 32'h0);
      chk("idle_done", 32'(done_v), 32'h0);
      chk("idle_ready", 32'(ready_v), 32'hF);
      step();
    end

    push_frame(9'h0A5, 8, 0, 1, f);
    handshake(0, 9'h0A5, 1'b0);
    watch(0, f, f, 1'b0, 1'b0, "nopar_a5");
    step();

    push_frame(9'h0A5, 8, 1, 1, f);
    handshake(1, 9'h0A5, 1'b0);
    watch(1, f, f, 1'b0, 1'b0, "even_a5");
    step();

    push_frame(9'h0A5, 8, 2, 1, f);
    handshake(2, 9'h0A5, 1'b0);
    watch(2, f, f, 1'b0, 1'b0, "odd_a5");
    step();

    push_frame(9'h07F, 7, 0, 2, f);
    push_frame(9'h000, 7, 0, 2, f2);
    handshake(3, 9'h07F, 1'b1);
    data_v[3] = 9'h000;
    watch(3, f + f2, f, 1'b1, 1'b0, "b2b");
    step();

    // Abandon a frame during data bit 3 of 0x3C.
    handshake(0, 9'h03C, 1'b0);
    repeat (18) step();
    chk("midrst_busy_before", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_tx", 32'(tx_v[0]), 32'd1);
    chk("midrst_busy", 32'(busy_v[0]), 32'd0);
    chk("midrst_done", 32'(done_v[0]), 32'd0);
    chk("midrst_ready", 32'(ready_v[0]), 32'd1);
    for (int k = 0; k < 30; k++) begin
      step();
      chk($sformatf("midrst_quiet_done_%0d", k), 32'(done_v[0]), 32'd0);
      chk($sformatf("midrst_quiet_tx_%0d", k), 32'(tx_v[0]), 32'd1);
    end
    push_frame(9'h081, 8, 0, 1, f);
    handshake(0, 9'h081, 1'b0);
    watch(0, f, f, 1'b0, 1'b0, "post_rst_81");
    step();

    push_frame(9'h05A, 8, 1, 1, f);
    handshake(1, 9'h05A, 1'b0);
    watch(1, f, f, 1'b0, 1'b1, "scramble_5a");
    step();

    // Reset coinciding with a valid word: the word must be dropped.
    valid_v[2] = 1'b1;
    data_v[2]  = 9'h0FF;
    rst        = 1'b1;
    step();
    rst        = 1'b0;
    valid_v[2] = 1'b0;
    chk("rst_valid_busy", 32'(busy_v[2]), 32'd0);
    chk("rst_valid_tx", 32'(tx_v[2]), 32'd1);
    step();
    step();
    chk("rst_valid_busy_later", 32'(busy_v[2]), 32'd0);
    chk("rst_valid_tx_later", 32'(tx_v[2]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
